// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, NOP encoding, fetch FSM states, default reset PC.
// S_FAULT exists only when FETCH_MISALIGN_CHECK_EN is defined.
package cpu_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        S_FAULT = 2'd3
`endif
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Next-PC selection for a retiring instruction: sequential pc+4 (wrapping) or branch target.
// Without FETCH_MISALIGN_CHECK_EN the target is word-aligned on load.
module pc_next (
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] next_pc
);

    always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
        // Target passes unmodified so a faulting PC shows the offending address.
        next_pc = branch_taken ? branch_target : pc + 32'd4;
`else
        next_pc = branch_taken ? {branch_target[31:2], 2'b00} : pc + 32'd4;
`endif
    end

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: fetches at pc, holds the word until retired.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (sticky misaligned-branch fault).
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [31:0] pc,
    input  logic        instr_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic        misalign_fault
`endif
);

    fetch_state_e state;
    fetch_state_e state_next;
    logic [31:0]  next_pc;
    logic         retire;
    logic         capture;
    logic         fault_now;

    pc_next u_pc_next (
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (next_pc)
    );

    assign retire    = (state == S_HOLD) && instr_ready;
    assign capture   = (state == S_FETCH) && imem_valid;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign fault_now = retire && branch_taken && is_misaligned(branch_target);
`else
    assign fault_now = 1'b0;
`endif

    assign imem_addr = pc;
    assign opcode    = instr[6:0];

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // NOTE: defaults first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        case (state)
            S_IDLE:  state_next = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) state_next = S_HOLD;
            end
            S_HOLD: begin
                if (instr_ready) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                    state_next = fault_now ? S_FAULT : S_FETCH;
`else
                    state_next = S_FETCH;
`endif
                end
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            S_FAULT: state_next = S_FAULT;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // Reset sits first so it overrides a same-cycle capture or retire.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            instr       <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else begin
            if (capture) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end
            if (retire) begin
                pc          <= next_pc;
                instr_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset)          misalign_fault <= 1'b0;
        else if (fault_now) misalign_fault <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized fetch/hold/branch traffic
// checked against a PC-sequence model; adapts to FETCH_MISALIGN_CHECK_EN.
module tb_instr_fetch;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [31:0] pc;
    logic        instr_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_fault;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cycle   = 0;
    logic [31:0] exp_pc;
    logic [31:0] last_word;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .opcode        (opcode),
        .pc            (pc),
        .instr_ready   (instr_ready),
        .branch_taken  (branch_taken),
        .branch_target (branch_target)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_fault(misalign_fault)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    // Model: one fetch at exp_pc after w wait cycles, held h extra cycles, then retired.
    task automatic fetch_one(input int w, input int h, input logic [31:0] word,
                             input logic taken, input logic [31:0] target, input string tag);
        for (int i = 0; i <= w; i++) begin
            n_tests++;
            if (imem_req !== 1'b1 || imem_addr !== exp_pc || instr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_fetch: req=%0b addr=%h valid=%0b, expected req=1 addr=%h valid=0",
                         tag, imem_req, imem_addr, instr_valid, exp_pc);
            end
            imem_valid = (i == w);
            imem_rdata = (i == w) ? word : $urandom;
            tick();
        end
        for (int i = 0; i <= h; i++) begin
            n_tests++;
            if (instr_valid !== 1'b1 || instr !== word || opcode !== word[6:0] ||
                pc !== exp_pc || imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_hold: valid=%0b instr=%h op=%b pc=%h req=%0b, expected 1 %h %b %h 0",
                         tag, instr_valid, instr, opcode, pc, imem_req, word, word[6:0], exp_pc);
            end
            instr_ready   = (i == h);
            // Non-retire cycles carry a taken branch and stray memory responses that must be ignored.
            branch_taken  = (i == h) ? taken : 1'b1;
            branch_target = (i == h) ? target : ($urandom & 32'hFFFF_FFFC);
            imem_valid    = (i == h) ? 1'b0 : 1'($urandom_range(0, 1));
            imem_rdata    = $urandom;
            tick();
        end
        instr_ready  = 1'b0;
        branch_taken = 1'b0;
        imem_valid   = 1'b0;
        exp_pc       = taken ? (target & 32'hFFFF_FFFC) : exp_pc + 32'd4;
        last_word    = word;
        n_tests++;
        if (instr_valid !== 1'b0 || instr !== word) begin
            n_fail++;
            $display("FAIL %s_retire: valid=%0b instr=%h, expected valid=0 instr=%h",
                     tag, instr_valid, instr, word);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; imem_valid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        tick(); tick();
        n_tests++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0000_0013 || pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_values: req=%0b valid=%0b instr=%h pc=%h, expected 0 0 00000013 00000000",
                     imem_req, instr_valid, instr, pc);
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        n_tests++;
        if (misalign_fault !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fault: got %0b, expected 0", misalign_fault);
        end
`endif
        reset = 1'b0;
        tick();
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL first_fetch_cycle1: req=%0b addr=%h, expected req=1 addr=00000000", imem_req, imem_addr);
        end
        imem_valid = 1'b1; imem_rdata = 32'h0000_0033;
        tick();
        imem_valid = 1'b0;
        n_tests++;
        if (instr_valid !== 1'b1 || opcode !== 7'b0110011 || instr !== 32'h0000_0033) begin
            n_fail++;
            $display("FAIL first_instr_cycle2: valid=%0b op=%b instr=%h, expected 1 0110011 00000033",
                     instr_valid, opcode, instr);
        end
        exp_pc = 32'h0;
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            instr_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0100;
            tick();
            n_tests++;
            if (instr_valid !== 1'b1 || instr !== 32'h0000_0033 || pc !== 32'h0 || imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: valid=%0b instr=%h pc=%h req=%0b, expected 1 00000033 00000000 0",
                         i, instr_valid, instr, pc, imem_req);
            end
        end
        instr_ready = 1'b1; branch_taken = 1'b0;
        tick();
        instr_ready = 1'b0;
        exp_pc = 32'h4;
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            n_fail++;
            $display("FAIL hold_release: req=%0b addr=%h, expected req=1 addr=00000004", imem_req, imem_addr);
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 3; i++) fetch_one(0, 1, $urandom, 1'b0, 32'h0, "seq");
        n_tests++;
        if (exp_pc !== 32'h10 || imem_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL branch_setup: addr=%h, expected 00000010", imem_addr);
        end
        fetch_one(1, 3, {25'h0, OPC_BRANCH}, 1'b1, 32'h0000_0040, "branch");
        n_tests++;
        if (imem_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL branch_target: addr=%h, expected 00000040", imem_addr);
        end
        fetch_one(0, 2, $urandom, 1'b0, 32'h0, "after_branch");
    endtask

    task automatic test_wrap();
        fetch_one(0, 0, $urandom, 1'b1, 32'hFFFF_FFFC, "to_top");
        fetch_one(0, 0, $urandom, 1'b0, 32'h0, "wrap");
        n_tests++;
        if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_addr: req=%0b addr=%h, expected req=1 addr=00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_back_to_back();
        int start;
        start = cycle;
        for (int i = 0; i < 4; i++) fetch_one(0, 0, $urandom, 1'b0, 32'h0, "b2b");
        n_tests++;
        if (cycle - start !== 8) begin
            n_fail++;
            $display("FAIL b2b_throughput: %0d cycles for 4 instructions, expected 8", cycle - start);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [31:0] tgt;
            tgt = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
            tgt = tgt & 32'hFFFF_FFFC;
`endif
            fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
                      1'($urandom_range(0, 1)), tgt, "rand");
        end
    endtask

    task automatic test_reset_midfetch();
        imem_valid = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        n_tests++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== NOP_INSTR || pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_midfetch: req=%0b valid=%0b instr=%h pc=%h, expected 0 0 00000013 00000000",
                     imem_req, instr_valid, instr, pc);
        end
        reset = 1'b0; imem_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_valid = 1'b0;
        n_tests++;
        if (instr_valid !== 1'b0 || instr !== NOP_INSTR || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL stale_in_idle: valid=%0b instr=%h req=%0b addr=%h, expected 0 00000013 1 00000000",
                     instr_valid, instr, imem_req, imem_addr);
        end
        reset = 1'b1; imem_valid = 1'b1; imem_rdata = 32'hCAFE_F00D;
        tick();
        reset = 1'b0; imem_valid = 1'b0;
        n_tests++;
        if (instr_valid !== 1'b0 || instr !== NOP_INSTR) begin
            n_fail++;
            $display("FAIL reset_vs_capture: valid=%0b instr=%h, expected 0 00000013", instr_valid, instr);
        end
        tick();
        exp_pc = 32'h0;
        fetch_one(0, 0, $urandom, 1'b0, 32'h0, "post_reset");
        imem_valid = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        imem_valid = 1'b0;
        reset = 1'b1; instr_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
        tick();
        reset = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0;
        n_tests++;
        if (pc !== 32'h0 || instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vs_retire: pc=%h valid=%0b, expected 00000000 0", pc, instr_valid);
        end
        tick();
        exp_pc = 32'h0;
    endtask

    task automatic test_misalign();
        fetch_one(0, 1, $urandom, 1'b0, 32'h0, "pre_mis");
        fetch_one(0, 1, $urandom, 1'b1, 32'h0000_0042, "mis");
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (misalign_fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h42) begin
                n_fail++;
                $display("FAIL misalign_fault[%0d]: fault=%0b req=%0b valid=%0b pc=%h, expected 1 0 0 00000042",
                         i, misalign_fault, imem_req, instr_valid, pc);
            end
            imem_valid = 1'b1; instr_ready = 1'b1;
            tick();
        end
        imem_valid = 1'b0; instr_ready = 1'b0;
`else
        n_tests++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            n_fail++;
            $display("FAIL misalign_forced: req=%0b addr=%h, expected req=1 addr=00000040", imem_req, imem_addr);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_hold();
        test_branch();
        test_wrap();
        test_back_to_back();
        test_random();
        test_reset_midfetch();
        test_misalign();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
